// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared decode definitions for the pipeline interlock controller:
// opcode/funct codes, Tuse/Tnew encodings, the mult/div sequencer state
// type and small opcode-group helpers including the destination decode.
package hazard_stall_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Tuse: cycles after D before the operand is consumed; NONE = not a source.
  typedef logic [1:0] tuse_t;
  localparam tuse_t TUSE_0    = 2'd0;
  localparam tuse_t TUSE_1    = 2'd1;
  localparam tuse_t TUSE_2    = 2'd2;
  localparam tuse_t TUSE_NONE = 2'd3;

  // Tnew: cycles until the result is available for forwarding.
  typedef logic [1:0] tnew_t;
  localparam tnew_t TNEW_0 = 2'd0;
  localparam tnew_t TNEW_1 = 2'd1;
  localparam tnew_t TNEW_2 = 2'd2;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  function automatic logic is_load_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // addi .. lui: immediate ALU group writing rt.
  function automatic logic is_ialu_op(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_LUI);
  endfunction

  function automatic logic [4:0] dst_decode(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (op == OP_RTYPE)                          return ir[15:11];
    else if (op == OP_JAL)                       return 5'd31;
    else if (is_ialu_op(op) || is_load_op(op))   return ir[20:16];
    else                                         return 5'd0;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_instr_class_dec.sv
// instr_class_dec: purely combinational per-stage instruction classifier.
//  ir           in  32  instruction word
//  rs, rt       out 5   source register fields
//  dst          out 5   destination register (0 = writes nothing)
//  tuse_rs/rt   out 2   Tuse per source (TUSE_NONE when not read)
//  tnew         out 2   Tnew as seen from the E stage
//  is_md        out 1   mult/div/mfhi/mthi/mflo/mtlo
//  is_md_start  out 1   mult/multu/div/divu
//  is_load      out 1   load instruction
module instr_class_dec
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output tuse_t       tuse_rs,
  output tuse_t       tuse_rt,
  output tnew_t       tnew,
  output logic        is_md,
  output logic        is_md_start,
  output logic        is_load
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_shamt;

  assign op           = ir[31:26];
  assign fn           = ir[5:0];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign dst          = dst_decode(ir);
  assign is_load      = is_load_op(op);
  assign is_md_start  = (op == OP_RTYPE) && (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  assign is_md        = is_md_start ||
                        ((op == OP_RTYPE) && (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO}));
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    tnew    = TNEW_0;
    if (op == OP_RTYPE) begin
      if (fn == FN_JR) begin
        tuse_rs = TUSE_0;
      end else begin
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
        tnew    = TNEW_1;
      end
    end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
      tuse_rs = TUSE_0;
      tuse_rt = TUSE_0;
    end else if (is_load_op(op)) begin
      tuse_rs = TUSE_1;
      tnew    = TNEW_2;
    end else if (is_store_op(op)) begin
      tuse_rs = TUSE_1;
      tuse_rt = TUSE_2;
    end else if (is_ialu_op(op)) begin
      tnew = TNEW_1;
      if (op != OP_LUI) tuse_rs = TUSE_1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline interlock for the 5-stage MIPS core.
// Inserts bubbles where forwarding cannot cover and sequences the mult/div unit.
//  clk       in  1   clock, rising edge
//  reset     in  1   async, active-low
//  IR_D/E/M  in  32  instructions in D, E, M
//  stall     out 1   freeze PC and D register
//  flush_E   out 1   load nop into E register (equals stall)
//  md_start  out 1   MD unit start pulse (IR_E is mult/multu/div/divu)
//  md_busy   out 1   MD result not yet valid
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        stall,
  output logic        flush_E,
  output logic        md_start,
  output logic        md_busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0] d_rs, d_rt, d_dst, e_rs, e_rt, e_dst, m_rs, m_rt, m_dst;
  tuse_t      d_tuse_rs, d_tuse_rt, e_tuse_rs, e_tuse_rt, m_tuse_rs, m_tuse_rt;
  tnew_t      d_tnew, e_tnew, m_tnew_raw, m_tnew;
  logic       d_is_md, d_is_md_start, d_is_load;
  logic       e_is_md, e_is_md_start, e_is_load;
  logic       m_is_md, m_is_md_start, m_is_load;

  instr_class_dec u_dec_d (
    .ir(IR_D), .rs(d_rs), .rt(d_rt), .dst(d_dst), .tuse_rs(d_tuse_rs), .tuse_rt(d_tuse_rt),
    .tnew(d_tnew), .is_md(d_is_md), .is_md_start(d_is_md_start), .is_load(d_is_load)
  );
  instr_class_dec u_dec_e (
    .ir(IR_E), .rs(e_rs), .rt(e_rt), .dst(e_dst), .tuse_rs(e_tuse_rs), .tuse_rt(e_tuse_rt),
    .tnew(e_tnew), .is_md(e_is_md), .is_md_start(e_is_md_start), .is_load(e_is_load)
  );
  instr_class_dec u_dec_m (
    .ir(IR_M), .rs(m_rs), .rt(m_rt), .dst(m_dst), .tuse_rs(m_tuse_rs), .tuse_rt(m_tuse_rt),
    .tnew(m_tnew_raw), .is_md(m_is_md), .is_md_start(m_is_md_start), .is_load(m_is_load)
  );

  // One stage further on, only a load still has a result outstanding.
  assign m_tnew = m_is_load ? TNEW_1 : TNEW_0;

  logic unused_dec;
  assign unused_dec = ^{d_dst, d_tnew, d_is_md_start, d_is_load,
                        e_rs, e_rt, e_tuse_rs, e_tuse_rt, e_is_md, e_is_load,
                        m_rs, m_rt, m_tuse_rs, m_tuse_rt, m_tnew_raw, m_is_md, m_is_md_start};

  function automatic logic hazard(input logic [4:0] src, input tuse_t tuse,
                                  input logic [4:0] dst, input tnew_t tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  logic data_stall;
  logic md_stall;

  assign data_stall = hazard(d_rs, d_tuse_rs, e_dst, e_tnew) |
                      hazard(d_rt, d_tuse_rt, e_dst, e_tnew) |
                      hazard(d_rs, d_tuse_rs, m_dst, m_tnew) |
                      hazard(d_rt, d_tuse_rt, m_dst, m_tnew);

  // Mult/div sequencer: counts busy cycles after the MD op leaves E.
  md_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             e_is_div;

  assign md_start = e_is_md_start;
  // funct bit 1 separates div/divu (0x1A/0x1B) from mult/multu (0x18/0x19).
  assign e_is_div = IR_E[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (md_start) begin
      state_nx = MD_BUSY;
      cnt_nx   = e_is_div ? DIV_LD : MULT_LD;
    end else if (state == MD_BUSY) begin
      if (cnt == CNT_ONE) begin
        state_nx = MD_IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign md_busy  = (state == MD_BUSY);
  assign md_stall = d_is_md & (md_busy | md_start);
  assign stall    = data_stall | md_stall;
  assign flush_E  = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver pushes expected outputs
// computed by a reference model; a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] IR_D, IR_E, IR_M;
  logic        stall, flush_E, md_start, md_busy;

  hazard_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .stall(stall), .flush_E(flush_E), .md_start(md_start), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   tag;
    logic stall;
    logic md_start;
    logic md_busy;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Reference model state: remaining busy cycles of the MD unit.
  int busy_left  = 0;
  bit prev_start = 0;
  bit prev_div   = 0;

  typedef struct {
    int dst;
    int tnew;        // as seen from E
    int src_reg[2];
    int src_use[2];  // 99 = not read
    bit md_cls;
    bit md_op;
    bit is_div;
  } ref_t;

  function automatic ref_t classify(input logic [31:0] ir);
    ref_t r;
    int op, rs, rt, rd, fn;
    op = int'(ir[31:26]); rs = int'(ir[25:21]); rt = int'(ir[20:16]);
    rd = int'(ir[15:11]); fn = int'(ir[5:0]);
    r.dst = 0; r.tnew = 0; r.src_reg[0] = rs; r.src_reg[1] = rt;
    r.src_use[0] = 99; r.src_use[1] = 99;
    r.md_cls = 0; r.md_op = 0; r.is_div = 0;
    case (op)
      0: begin
        r.dst = rd;
        if (fn == 8) r.src_use[0] = 0;
        else begin
          r.src_use[0] = 1; r.src_use[1] = 1; r.tnew = 1;
        end
        r.md_op  = (fn >= 'h18 && fn <= 'h1B);
        r.md_cls = r.md_op || (fn >= 'h10 && fn <= 'h13);
        r.is_div = (fn == 'h1A || fn == 'h1B);
      end
      3: r.dst = 31;
      4, 5: begin r.src_use[0] = 0; r.src_use[1] = 0; end
      'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E: begin
        r.dst = rt; r.tnew = 1; r.src_use[0] = 1;
      end
      'h0F: begin r.dst = rt; r.tnew = 1; end
      'h20, 'h21, 'h23, 'h24, 'h25: begin r.dst = rt; r.tnew = 2; r.src_use[0] = 1; end
      'h28, 'h29, 'h2B: begin r.src_use[0] = 1; r.src_use[1] = 2; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic void chk(input string nm, input int tag, input logic act, input logic req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s cycle=%0d got=%0b expected=%0b", nm, tag, act, req);
  endfunction

  // One clock: advance the model across the edge, then apply inputs and push expectation.
  task automatic cycle(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic rst_val);
    ref_t rd, re, rm;
    int   tnew_m;
    bit   ds, mst;
    exp_t x;
    @(posedge clk);
    if (!reset)          busy_left = 0;
    else if (prev_start) busy_left = prev_div ? DIV_N : MULT_N;
    else if (busy_left > 0) busy_left--;
    #1;
    reset = rst_val;
    IR_D = d; IR_E = e; IR_M = m;
    if (!rst_val) busy_left = 0;
    cyc++;
    rd = classify(d); re = classify(e); rm = classify(m);
    tnew_m = (re.tnew > 0) ? 0 : 0;
    tnew_m = (rm.tnew > 0) ? rm.tnew - 1 : 0;
    ds = 0;
    for (int i = 0; i < 2; i++) begin
      if (rd.src_reg[i] != 0) begin
        if (rd.src_reg[i] == re.dst && rd.src_use[i] < re.tnew) ds = 1;
        if (rd.src_reg[i] == rm.dst && rd.src_use[i] < tnew_m)  ds = 1;
      end
    end
    mst        = rd.md_cls && ((busy_left > 0) || re.md_op);
    x.tag      = cyc;
    x.stall    = ds | mst;
    x.md_start = re.md_op;
    x.md_busy  = (busy_left > 0);
    prev_start = re.md_op;
    prev_div   = re.is_div;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'h0004};
  endfunction

  function automatic logic [31:0] rand_instr(input bit allow_md);
    int a, b, c, k;
    a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
    k = $urandom_range(0, allow_md ? 13 : 11);
    case (k)
      0:  return 32'h0;
      1:  return rtype(a, b, c, 'h21);
      2:  return itype('h23, a, b);
      3:  return itype('h2B, a, b);
      4:  return itype('h04, a, b);
      5:  return itype('h05, a, b);
      6:  return rtype(a, 0, 0, 'h08);
      7:  return itype('h0D, a, b);
      8:  return itype('h0F, 0, b);
      9:  return {6'h03, 26'h10};
      10: return itype('h09, a, b);
      11: return rtype(0, 0, c, $urandom_range('h10, 'h13));
      12: return rtype(a, b, 0, $urandom_range('h18, 'h19));
      default: return rtype(a, b, 0, $urandom_range('h1A, 'h1B));
    endcase
  endfunction

  // Monitor: outputs are combinational and valid every cycle; compare at negedge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("stall",    x.tag, stall,    x.stall);
        chk("flush_E",  x.tag, flush_E,  x.stall);
        chk("md_start", x.tag, md_start, x.md_start);
        chk("md_busy",  x.tag, md_busy,  x.md_busy);
      end
    end
  end

  initial begin
    logic [31:0] DIVI, MULI, MFHI;
    DIVI = 32'h0022001A; MULI = 32'h00220018; MFHI = 32'h00002010;
    reset = 1'b0; IR_D = '0; IR_E = '0; IR_M = '0;
    cycle(32'h0, 32'h0, 32'h0, 1'b0);
    cycle(32'h0, 32'h0, 32'h0, 1'b1);
    // load-use, then resolved one cycle later
    cycle(32'h00211021, 32'h8C010000, 32'h0, 1'b1);
    cycle(32'h00211021, 32'h0, 32'h8C010000, 1'b1);
    // branch after ALU, ALU after ALU
    cycle(32'h10600004, 32'h00221821, 32'h0, 1'b1);
    cycle(32'h00631821, 32'h00221821, 32'h0, 1'b1);
    // $0 destination never hazards
    cycle(32'h00001021, 32'h8C000000, 32'h0, 1'b1);
    // div with mfhi waiting in D
    cycle(MFHI, DIVI, 32'h0, 1'b1);
    repeat (DIV_N) cycle(MFHI, 32'h0, 32'h0, 1'b1);
    cycle(MFHI, 32'h0, 32'h0, 1'b1);
    // mult with non-MD instruction in D
    cycle(32'h00221821, MULI, 32'h0, 1'b1);
    repeat (MULT_N + 1) cycle(32'h0, 32'h0, 32'h0, 1'b1);
    // reset while busy at cnt==3
    cycle(32'h0, DIVI, 32'h0, 1'b1);
    repeat (7) cycle(32'h0, 32'h0, 32'h0, 1'b1);
    cycle(32'h0, 32'h0, 32'h0, 1'b0);
    cycle(32'h0, 32'h0, 32'h0, 1'b1);
    cycle(MFHI, 32'h0, 32'h0, 1'b1);
    // randomized traffic with occasional reset
    repeat (400) begin
      cycle(rand_instr(1'b1), rand_instr($urandom_range(0, 5) == 0), rand_instr(1'b1),
            ($urandom_range(0, 49) != 0));
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain got=%0d pending expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
